// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures PWM period/high time and reports duty in tenths (0..10).
// Optional glitch filter on the synchronized input: define PWM_DEC_GLITCH_FILTER_EN.
module pwm_duty_decoder #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic [3:0]       duty_out,
  output logic             stuck_out,
  output logic             meas_valid,
  output logic             overrun
);
  localparam int N  = CNT_W + 4;
  localparam int CW = $clog2(N + 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic s, s_d, rise;
  logic [CNT_W-1:0] per_cnt, hi_cnt, cap_per, cap_hi, div_per, div_hi, rem, rem_nxt, res_per, res_hi;
  logic [N-1:0] dvd, quot;
  logic [CW-1:0] cnt;
  logic [CNT_W:0] r2, diff;
  logic [3:0] res_duty;
  logic start, fin, res_v, busy, take, drop, tmo, ge, load;
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], pwm_in};
`ifdef PWM_DEC_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] flt_cnt;
  // s follows the synchronizer only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      s <= 1'b0;
      flt_cnt <= '0;
    end else if (sync[SYNC_STAGES-1] == s) flt_cnt <= '0;
    else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      s <= sync[SYNC_STAGES-1];
      flt_cnt <= '0;
    end else flt_cnt <= flt_cnt + 1'b1;
`else
  assign s = sync[SYNC_STAGES-1];
`endif
  always_comb begin
    rise = s & ~s_d;
    busy = start | (cnt > CW'(1));
    take = (state == MEASURE) & rise & ~busy;
    drop = (state == MEASURE) & rise & busy;
    tmo = (state == MEASURE) & ~rise & (per_cnt == MAX);
    load = res_v | tmo;
    r2 = {rem, dvd[N-1]};
    diff = r2 - {1'b0, div_per};
    ge = r2 >= {1'b0, div_per};
    rem_nxt = ge ? diff[CNT_W-1:0] : r2[CNT_W-1:0];
  end
  // Counters include the current cycle: a rise restarts them at 1 and the
  // pre-edge values are exactly the rise-to-rise period and its high count.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
      s_d <= 1'b0;
      per_cnt <= '0;
      hi_cnt <= '0;
      cap_per <= '0;
      cap_hi <= '0;
      div_per <= '0;
      div_hi <= '0;
      rem <= '0;
      dvd <= '0;
      quot <= '0;
      cnt <= '0;
      start <= 1'b0;
      fin <= 1'b0;
      res_v <= 1'b0;
      res_per <= '0;
      res_hi <= '0;
      res_duty <= '0;
      period_out <= '0;
      high_out <= '0;
      duty_out <= '0;
      stuck_out <= 1'b0;
      meas_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      s_d <= s;
      start <= take;
      fin <= cnt == CW'(1);
      res_v <= fin;
      if (rise) begin
        state <= MEASURE;
        per_cnt <= CNT_W'(1);
        hi_cnt <= CNT_W'(1);
      end else if (tmo) state <= IDLE;
      else if (state == MEASURE) begin
        per_cnt <= per_cnt + 1'b1;
        hi_cnt <= hi_cnt + CNT_W'(s);
      end
      if (take) begin
        cap_per <= per_cnt;
        cap_hi <= hi_cnt;
      end
      // Restoring divide of high*10 by period, one quotient bit per cycle
      if (start) begin
        div_per <= cap_per;
        div_hi <= cap_hi;
        dvd <= N'({cap_hi, 3'b000}) + N'({cap_hi, 1'b0});
        rem <= '0;
        quot <= '0;
        cnt <= CW'(N);
      end else if (cnt != '0) begin
        rem <= rem_nxt;
        dvd <= {dvd[N-2:0], 1'b0};
        quot <= {quot[N-2:0], ge};
        cnt <= cnt - 1'b1;
      end
      if (fin) begin
        res_per <= div_per;
        res_hi <= div_hi;
        res_duty <= (quot > N'(10)) ? 4'd10 : quot[3:0];
      end
      if (load) begin
        period_out <= tmo ? MAX : res_per;
        high_out <= tmo ? (s ? MAX : '0) : res_hi;
        duty_out <= tmo ? (s ? 4'd10 : 4'd0) : res_duty;
        stuck_out <= tmo;
        meas_valid <= 1'b1;
      end else if (meas_ready) meas_valid <= 1'b0;
      if (drop | (load & meas_valid & ~meas_ready)) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: scoreboard bench for pwm_duty_decoder (reduced CNT_W keeps timeouts short).
module tb_pwm_duty_decoder;
  localparam int CW = 12;
  localparam int SS = 2;
  localparam int MAXV = (1 << CW) - 1;
`ifdef PWM_DEC_GLITCH_FILTER_EN
  localparam int LAT = SS + CW + 7 + 3;
`else
  localparam int LAT = SS + CW + 7;
`endif
  logic clk = 0, rst_n = 0, pwm_in = 0, meas_ready = 1;
  logic [CW-1:0] period_out, high_out;
  logic [3:0] duty_out;
  logic stuck_out, meas_valid, overrun;
  logic [31:0] obs, fix;
  logic [31:0] q[$];
  int n_chk = 0, n_err = 0, cyc = 0, mode = 0, n_seen = 0, rise_cyc = 0;
  int prev_p = 0, prev_h = 0;
  bit have_prev = 0, lat_arm = 0;
  pwm_duty_decoder #(.CNT_W(CW), .SYNC_STAGES(SS), .FILTER_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .meas_ready(meas_ready),
    .period_out(period_out), .high_out(high_out), .duty_out(duty_out),
    .stuck_out(stuck_out), .meas_valid(meas_valid), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign obs = 32'({stuck_out, duty_out, high_out, period_out});
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [31:0] res(input int p, input int h, input int d, input int st);
    return 32'((st << 28) | (d << 24) | (h << 12) | p);
  endfunction
  function automatic logic [31:0] exp_of(input int p, input int h);
    int d = h * 10 / p;
    return res(p, h, (d > 10) ? 10 : d, 0);
  endfunction
  initial forever begin
    @(negedge clk);
    #1;
    if (meas_valid && meas_ready) begin
      n_seen++;
      if (mode == 1) begin
        if (q.size() == 0) check("sb_extra", obs, '0);
        else check("sb", obs, q.pop_front());
      end else if (mode == 2) check("fixed", obs, fix);
    end
  end
  task automatic gen(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        if (c == 0) begin
          if (have_prev && mode == 1) q.push_back(exp_of(prev_p, prev_h));
          prev_p = p;
          prev_h = h;
          have_prev = 1;
          rise_cyc = cyc;
        end
        pwm_in = c < h;
        if (lat_arm && meas_valid) begin
          check("latency", cyc - rise_cyc - 1, LAT);
          lat_arm = 0;
        end
      end
  endtask
  task automatic drain(input int bound);
    int t = 0;
    while (q.size() != 0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    check("drain", q.size(), 0);
  endtask
  task automatic do_reset();
    mode = 0;
    have_prev = 0;
    @(negedge clk);
    #2 rst_n = 1;
    pwm_in = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
  endtask
  initial begin
    bit seen;
    #1 rst_n = 1;
    repeat (2) @(negedge clk);
    check("reset", {overrun, meas_valid, obs[30:0]}, '0);
    rst_n = 0;
    mode = 1;
    lat_arm = 1;
    gen(40, 20, 3);
    gen(20, 7, 3);
    gen(100, 99, 2);
    @(negedge clk);
    pwm_in = 0;
    have_prev = 0;
    q.push_back(res(MAXV, 0, 0, 1));
    drain(4400);
    @(negedge clk);
    pwm_in = 1;
    q.push_back(res(MAXV, MAXV, 10, 1));
    drain(4400);
    check("lat_seen", lat_arm, 0);
    check("overrun_clean", overrun, 0);
    @(negedge clk);
    pwm_in = 0;
    mode = 0;
    have_prev = 0;
    meas_ready = 0;
    gen(20, 5, 1);
    gen(30, 15, 1);
    gen(40, 10, 1);
    check("ovr_result", obs, exp_of(30, 15));
    check("ovr_valid", meas_valid, 1);
    check("ovr_flag", overrun, 1);
    @(negedge clk);
    meas_ready = 1;
    @(negedge clk);
    #1;
    check("accept_drop", meas_valid, 0);
    check("ovr_sticky", overrun, 1);
    do_reset();
    check("ovr_cleared", overrun, 0);
    mode = 2;
    fix = res(10, 5, 5, 0);
    n_seen = 0;
    gen(10, 5, 8);
    repeat (30) @(negedge clk);
    check("p10_seen", n_seen > 0, 1);
    check("p10_ovr", overrun, 1);
    do_reset();
    mode = 2;
    fix = res(12, 6, 5, 0);
    n_seen = 0;
    gen(12, 6, 8);
    repeat (30) @(negedge clk);
    check("p12_seen", n_seen > 0, 1);
    check("p12_ovr", overrun, 1);
    mode = 0;
    @(negedge clk);
    pwm_in = 1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1;
    pwm_in = 0;
    #1;
    check("rst_mid", {overrun, meas_valid, obs[30:0]}, '0);
    @(negedge clk);
    rst_n = 0;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      seen |= meas_valid;
    end
    check("no_stray", seen, 0);
`ifdef PWM_DEC_GLITCH_FILTER_EN
    mode = 2;
    fix = res(40, 20, 5, 0);
    n_seen = 0;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        pwm_in = (c < 20) || (c == 28) || (c == 29);
      end
    repeat (40) @(negedge clk);
    check("glitch_seen", n_seen > 0, 1);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
